// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS32 pipeline hazard controller: scoreboard entry,
// controller FSM states and instruction type encodings.
package mips_pipe_pkg;

  localparam int SB_RD_W = 5;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               regwrite;
    logic               is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

  typedef enum logic [2:0] {
    TYPE_RR_ALU = 3'd0,
    TYPE_RM_ALU = 3'd1,
    TYPE_LOAD   = 3'd2,
    TYPE_STORE  = 3'd3,
    TYPE_BRANCH = 3'd4,
    TYPE_HALT   = 3'd5
  } instr_type_e;

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer priority encoder: finds the lowest scoreboard index whose
// destination matches a source register (register 0 never matches).
module hazard_match
  import mips_pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int FWD_W = 2
) (
  input  sb_entry_t [DEPTH-2:0] sb_i,
  input  logic [SB_RD_W-1:0]    src_i,
  input  logic                  use_i,
  output logic                  hit_o,
  output logic [FWD_W-1:0]      idx_o,
  output logic                  is_load_o
);

  // Scan oldest to youngest so the youngest match is the last to assign.
  always_comb begin
    hit_o     = 1'b0;
    idx_o     = '0;
    is_load_o = 1'b0;
    for (int j = DEPTH - 2; j >= 0; j--) begin
      if (use_i && (src_i != '0) && sb_i[j].valid && sb_i[j].regwrite &&
          (sb_i[j].rd == src_i)) begin
        hit_o     = 1'b1;
        idx_o     = FWD_W'(j);
        is_load_o = sb_i[j].is_load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: forwarding selects, load-use stall, branch flush
// and HLT drain. Optional PIPE_HAZ_STATS_EN adds stall/flush counters.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int FWD_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              id_is_halt,
  input  logic              br_taken,
  output logic              issue,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              flush,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic              halted
`ifdef PIPE_HAZ_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  hz_state_e             state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [FWD_W-1:0]      fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic                  halted_q;
  logic                  hit_a, hit_b, ld_a, ld_b, lu_a, lu_b, run;
  logic [FWD_W-1:0]      idx_a, idx_b;
  logic                  sb_retire_unused;

  // The oldest entry only retires; the register file already sees its write.
  assign sb_retire_unused = ^sb_q[DEPTH-1];

  hazard_match #(.DEPTH(DEPTH), .FWD_W(FWD_W)) u_match_rs (
    .sb_i     (sb_q[DEPTH-2:0]),
    .src_i    (SB_RD_W'(id_rs)),
    .use_i    (id_uses_rs),
    .hit_o    (hit_a),
    .idx_o    (idx_a),
    .is_load_o(ld_a)
  );

  hazard_match #(.DEPTH(DEPTH), .FWD_W(FWD_W)) u_match_rt (
    .sb_i     (sb_q[DEPTH-2:0]),
    .src_i    (SB_RD_W'(id_rt)),
    .use_i    (id_uses_rt),
    .hit_o    (hit_b),
    .idx_o    (idx_b),
    .is_load_o(ld_b)
  );

  // A load producer at index j has data after pipeline register j+1.
  assign lu_a = hit_a & ld_a & ((int'(idx_a) + 1) < LOAD_STAGE);
  assign lu_b = hit_b & ld_b & ((int'(idx_b) + 1) < LOAD_STAGE);
  assign run  = (state_q == RUN);

  always_comb begin
    flush       = br_taken & run;
    stall       = run ? (id_valid & (lu_a | lu_b) & ~br_taken) : 1'b1;
    issue       = id_valid & ~stall & ~br_taken & run;
    pc_write    = ~stall;
    if_id_write = ~stall;

    fwd_a_d = '0;
    fwd_b_d = '0;
    if (issue) begin
      fwd_a_d = hit_a ? (idx_a + FWD_W'(1)) : '0;
      fwd_b_d = hit_b ? (idx_b + FWD_W'(1)) : '0;
    end

    sb_d = '0;
    if (issue) begin
      sb_d[0] = '{valid: 1'b1, rd: SB_RD_W'(id_rd),
                  regwrite: id_regwrite, is_load: id_is_load};
    end
    for (int j = 1; j < DEPTH; j++) begin
      sb_d[j] = sb_q[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q     <= '0;
      fwd_a_q  <= '0;
      fwd_b_q  <= '0;
      state_q  <= RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      sb_q    <= sb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      case (state_q)
        RUN: begin
          if (issue && id_is_halt) begin
            state_q <= DRAIN;
            cnt_q   <= CNT_W'(DEPTH);
          end
        end
        DRAIN: begin
          if (cnt_q == '0) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign fwd_a  = fwd_a_q;
  assign fwd_b  = fwd_b_q;
  assign halted = halted_q;

`ifdef PIPE_HAZ_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (run && stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (default and DEPTH=5/LOAD_STAGE=3
// instances); expected responses are queued and checked by a monitor.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic       id_regwrite = 1'b0, id_is_load = 1'b0, id_is_halt = 1'b0;
  logic       br_taken = 1'b0;

  logic       issue, stall, pc_write, if_id_write, flush, halted;
  logic [1:0] fwd_a, fwd_b;
  logic       issue5, stall5, pc_write5, if_id_write5, flush5, halted5;
  logic [2:0] fwd_a5, fwd_b5;
`ifdef PIPE_HAZ_STATS_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt5, flush_cnt5;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_halt(id_is_halt),
    .br_taken(br_taken), .issue(issue), .stall(stall), .pc_write(pc_write),
    .if_id_write(if_id_write), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .halted(halted)
`ifdef PIPE_HAZ_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_hazard_ctrl #(.DEPTH(5), .LOAD_STAGE(3)) u_dut5 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_halt(id_is_halt),
    .br_taken(br_taken), .issue(issue5), .stall(stall5), .pc_write(pc_write5),
    .if_id_write(if_id_write5), .flush(flush5), .fwd_a(fwd_a5), .fwd_b(fwd_b5),
    .halted(halted5)
`ifdef PIPE_HAZ_STATS_EN
    , .stall_cnt(stall_cnt5), .flush_cnt(flush_cnt5)
`endif
  );

  typedef struct {
    logic       rst, valid;
    logic [4:0] rs, rt, rd;
    logic       urs, urt, rw, ld, hlt, br;
    logic       chk, which;
    logic       iss, st, fl, h;
    logic [2:0] fa, fb;
    string      nm;
  } vec_t;

  vec_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic which_g  = 1'b0;

  function automatic vec_t ins(input string nm, input logic v,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt,
                               input logic [4:0] rd, input logic rw,
                               input logic ld, input logic hlt, input logic br);
    vec_t r;
    r.rst = 1'b0; r.valid = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
    r.rd = rd; r.rw = rw; r.ld = ld; r.hlt = hlt; r.br = br;
    r.chk = 1'b0; r.which = 1'b0;
    r.iss = 1'b0; r.st = 1'b0; r.fl = 1'b0; r.h = 1'b0; r.fa = '0; r.fb = '0;
    r.nm = nm;
    return r;
  endfunction

  function automatic vec_t idle(input string nm);
    return ins(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; id_valid = v.valid; id_rs = v.rs; id_rt = v.rt;
    id_uses_rs = v.urs; id_uses_rt = v.urt; id_rd = v.rd;
    id_regwrite = v.rw; id_is_load = v.ld; id_is_halt = v.hlt; br_taken = v.br;
    exp_q.push_back(v);
  endtask

  task automatic go(input vec_t v, input logic iss, input logic st, input logic fl,
                    input logic [2:0] fa, input logic [2:0] fb, input logic h);
    v.chk = 1'b1; v.which = which_g;
    v.iss = iss; v.st = st; v.fl = fl; v.fa = fa; v.fb = fb; v.h = h;
    drive(v);
  endtask

  task automatic rst_cycle();
    vec_t r;
    r = idle("reset");
    r.rst = 1'b1;
    drive(r);
  endtask

  task automatic chk(input string nm, input string f, input logic [2:0] act,
                     input logic [2:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d expected %0d", nm, f, act, exp);
    end
  endtask

  // Monitor: compares the DUT against the queued expectation each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        vec_t v;
        v = exp_q.pop_front();
        if (v.chk) begin
          chk(v.nm, "issue",       {2'b0, v.which ? issue5 : issue},             {2'b0, v.iss});
          chk(v.nm, "stall",       {2'b0, v.which ? stall5 : stall},             {2'b0, v.st});
          chk(v.nm, "flush",       {2'b0, v.which ? flush5 : flush},             {2'b0, v.fl});
          chk(v.nm, "pc_write",    {2'b0, v.which ? pc_write5 : pc_write},       {2'b0, ~v.st});
          chk(v.nm, "if_id_write", {2'b0, v.which ? if_id_write5 : if_id_write}, {2'b0, ~v.st});
          chk(v.nm, "fwd_a",       v.which ? fwd_a5 : {1'b0, fwd_a},             v.fa);
          chk(v.nm, "fwd_b",       v.which ? fwd_b5 : {1'b0, fwd_b},             v.fb);
          chk(v.nm, "halted",      {2'b0, v.which ? halted5 : halted},           {2'b0, v.h});
          $display("[%0t] vector %s checked (dut%0s)", $time, v.nm, v.which ? "5" : "3");
        end
      end
    end
  end

  initial begin
    rst_cycle();
    rst_cycle();
    which_g = 1'b0;
    //                                              v rs rt us ut rd rw ld ht br     iss st fl fa fb h
    go(idle("reset_state"),                                                           0, 0, 0, 0, 0, 0);
    go(ins("add_r3",        1, 1, 2, 1, 1, 3, 1, 0, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(ins("sub_r5_r3_r1",  1, 3, 1, 1, 1, 5, 1, 0, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(idle("ex_sub"),                                                                0, 0, 0, 1, 0, 0);
    go(idle("idle_fwd0"),                                                             0, 0, 0, 0, 0, 0);
    go(ins("lw_r2",         1, 1, 0, 1, 0, 2, 1, 1, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(ins("add_r4_stall",  1, 2, 2, 1, 1, 4, 1, 0, 0, 0),                              0, 1, 0, 0, 0, 0);
    go(ins("add_r4_issue",  1, 2, 2, 1, 1, 4, 1, 0, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(idle("ex_add_r4"),                                                             0, 0, 0, 2, 2, 0);
    go(ins("lw_r2_again",   1, 1, 0, 1, 0, 2, 1, 1, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(ins("lu_with_br",    1, 2, 2, 1, 1, 4, 1, 0, 0, 1),                              0, 0, 1, 0, 0, 0);
    go(ins("or_r6_r4_r0",   1, 4, 0, 1, 1, 6, 1, 0, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(idle("ex_or_r6"),                                                              0, 0, 0, 0, 0, 0);
    go(ins("lw_r0",         1, 1, 0, 1, 0, 0, 1, 1, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(ins("add_r7_r0_r0",  1, 0, 0, 1, 1, 7, 1, 0, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(ins("addi_r6",       1, 1, 0, 1, 0, 6, 1, 0, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(ins("add_r6",        1, 2, 0, 1, 0, 6, 1, 0, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(ins("sub_r8_r6_r6",  1, 6, 6, 1, 1, 8, 1, 0, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(idle("ex_sub_r8"),                                                             0, 0, 0, 1, 1, 0);
    go(ins("hlt_flushed",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1),                              0, 0, 1, 0, 0, 0);
    go(ins("add_r9_run",    1, 1, 2, 1, 1, 9, 1, 0, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(ins("hlt_issue",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0),                              1, 0, 0, 0, 0, 0);
    go(ins("drain1",        1, 1, 2, 1, 1, 9, 1, 0, 0, 0),                              0, 1, 0, 0, 0, 0);
    go(ins("drain2_br",     1, 1, 2, 1, 1, 9, 1, 0, 0, 1),                              0, 1, 0, 0, 0, 0);
    go(idle("drain3"),                                                                0, 1, 0, 0, 0, 0);
    go(idle("drain4"),                                                                0, 1, 0, 0, 0, 0);
    go(idle("halted"),                                                                0, 1, 0, 0, 0, 1);
    go(ins("halted_br",     1, 1, 2, 1, 1, 9, 1, 0, 0, 1),                              0, 1, 0, 0, 0, 1);
    rst_cycle();
    go(idle("post_rst"),                                                              0, 0, 0, 0, 0, 0);
    go(ins("run_again",     1, 1, 2, 1, 1, 9, 1, 0, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(ins("hlt_issue2",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0),                              1, 0, 0, 0, 0, 0);
    go(idle("mid_drain"),                                                             0, 1, 0, 0, 0, 0);
    rst_cycle();
    go(ins("add_after_rst", 1, 1, 2, 1, 1, 9, 1, 0, 0, 0),                              1, 0, 0, 0, 0, 0);

    // Deeper pipeline with a later load-data point.
    rst_cycle();
    which_g = 1'b1;
    go(ins("d5_lw_r7",      1, 1, 0, 1, 0, 7, 1, 1, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(ins("d5_or_stall1",  1, 7, 1, 1, 1, 9, 1, 0, 0, 0),                              0, 1, 0, 0, 0, 0);
    go(ins("d5_or_stall2",  1, 7, 1, 1, 1, 9, 1, 0, 0, 0),                              0, 1, 0, 0, 0, 0);
    go(ins("d5_or_issue",   1, 7, 1, 1, 1, 9, 1, 0, 0, 0),                              1, 0, 0, 0, 0, 0);
    go(idle("d5_ex_or"),                                                              0, 0, 0, 3, 0, 0);

    repeat (3) @(posedge clk);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
